// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle layout, NOP encoding and ALU operation codes.
package pipeline_pkg;

  localparam int LARGURA_CONTROLE     = 10;
  localparam int BIT_HABILITA_ESCRITA = 0;
  localparam int BIT_LE_MEMORIA       = 1;
  localparam int BIT_ESCREVE_MEMORIA  = 2;
  localparam int BIT_MEM_PARA_REG     = 3;
  localparam int BIT_ALU_SRC          = 4;
  localparam int BIT_DESVIO           = 5;
  localparam int CAMPO_ALU_OP         = 6;
  localparam int LARGURA_ALU_OP       = 4;

  localparam logic [LARGURA_CONTROLE-1:0] CONTROLE_NOP = '0;

  typedef enum logic [LARGURA_ALU_OP-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

endpackage

// File: rtl/detector_hazard_carga.sv
// Load-use hazard detector: a load in EX whose destination is read by the valid ID instruction.
module detector_hazard_carga #(
  parameter int LARGURA_ENDERECO = 5
) (
  input  logic                        valido_id,
  input  logic                        valido_ex,
  input  logic                        le_memoria_ex,
  input  logic [LARGURA_ENDERECO-1:0] endereco_destino_ex,
  input  logic [LARGURA_ENDERECO-1:0] endereco_fonte1,
  input  logic [LARGURA_ENDERECO-1:0] endereco_fonte2,
  output logic                        carga_uso
);

  // Both sources are compared even if the instruction ignores one; a false stall is harmless.
  assign carga_uso = valido_id && valido_ex && le_memoria_ex &&
                     (endereco_destino_ex != '0) &&
                     ((endereco_destino_ex == endereco_fonte1) ||
                      (endereco_destino_ex == endereco_fonte2));

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// flush/freeze handling and a saturating bubble counter.
module id_ex_register #(
  parameter int LARGURA_DADO     = 32,
  parameter int LARGURA_ENDERECO = 5,
  parameter int LARGURA_CONTROLE = pipeline_pkg::LARGURA_CONTROLE,
  parameter int LARGURA_CONTADOR = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valido_id,
  input  logic [LARGURA_DADO-1:0]     pc_id,
  input  logic [LARGURA_DADO-1:0]     dado_fonte1,
  input  logic [LARGURA_DADO-1:0]     dado_fonte2,
  input  logic [LARGURA_ENDERECO-1:0] endereco_fonte1,
  input  logic [LARGURA_ENDERECO-1:0] endereco_fonte2,
  input  logic [LARGURA_ENDERECO-1:0] endereco_destino,
  input  logic [LARGURA_DADO-1:0]     imediato_id,
  input  logic [LARGURA_CONTROLE-1:0] controle_id,
  input  logic                        wb_habilita_escrita,
  input  logic [LARGURA_ENDERECO-1:0] wb_endereco_destino,
  input  logic [LARGURA_DADO-1:0]     wb_dado,
  input  logic                        descarta,
  input  logic                        congela,
  output logic                        parar_id,
  output logic                        valido_ex,
  output logic [LARGURA_DADO-1:0]     pc_ex,
  output logic [LARGURA_DADO-1:0]     imediato_ex,
  output logic [LARGURA_DADO-1:0]     dado_fonte1_ex,
  output logic [LARGURA_DADO-1:0]     dado_fonte2_ex,
  output logic [LARGURA_ENDERECO-1:0] endereco_fonte1_ex,
  output logic [LARGURA_ENDERECO-1:0] endereco_fonte2_ex,
  output logic [LARGURA_ENDERECO-1:0] endereco_destino_ex,
  output logic [LARGURA_CONTROLE-1:0] controle_ex,
  output logic [LARGURA_CONTADOR-1:0] contador_bolhas
);

  localparam logic [LARGURA_CONTADOR-1:0] CONTADOR_UM = LARGURA_CONTADOR'(1);
  localparam logic [LARGURA_CONTROLE-1:0] NOP = LARGURA_CONTROLE'(pipeline_pkg::CONTROLE_NOP);

  logic                    carga_uso;
  logic                    bypass1, bypass2;
  logic [LARGURA_DADO-1:0] operando1, operando2;

  detector_hazard_carga #(
    .LARGURA_ENDERECO(LARGURA_ENDERECO)
  ) u_detector (
    .valido_id          (valido_id),
    .valido_ex          (valido_ex),
    .le_memoria_ex      (controle_ex[pipeline_pkg::BIT_LE_MEMORIA]),
    .endereco_destino_ex(endereco_destino_ex),
    .endereco_fonte1    (endereco_fonte1),
    .endereco_fonte2    (endereco_fonte2),
    .carga_uso          (carga_uso)
  );

  assign parar_id = (carga_uso || congela) && !descarta;

  // x0 never bypasses, so a read of x0 keeps the register_file zero.
  assign bypass1   = wb_habilita_escrita && (wb_endereco_destino == endereco_fonte1) &&
                     (endereco_fonte1 != '0);
  assign bypass2   = wb_habilita_escrita && (wb_endereco_destino == endereco_fonte2) &&
                     (endereco_fonte2 != '0);
  assign operando1 = bypass1 ? wb_dado : dado_fonte1;
  assign operando2 = bypass2 ? wb_dado : dado_fonte2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valido_ex           <= 1'b0;
      pc_ex               <= '0;
      imediato_ex         <= '0;
      dado_fonte1_ex      <= '0;
      dado_fonte2_ex      <= '0;
      endereco_fonte1_ex  <= '0;
      endereco_fonte2_ex  <= '0;
      endereco_destino_ex <= '0;
      controle_ex         <= NOP;
      contador_bolhas     <= '0;
    end else if (descarta || (!congela && carga_uso)) begin
      // Flush beats freeze; only load-use bubbles are counted.
      valido_ex           <= 1'b0;
      pc_ex               <= '0;
      imediato_ex         <= '0;
      dado_fonte1_ex      <= '0;
      dado_fonte2_ex      <= '0;
      endereco_fonte1_ex  <= '0;
      endereco_fonte2_ex  <= '0;
      endereco_destino_ex <= '0;
      controle_ex         <= NOP;
      if (!descarta && (contador_bolhas != '1))
        contador_bolhas <= contador_bolhas + CONTADOR_UM;
    end else if (!congela) begin
      valido_ex           <= valido_id;
      pc_ex               <= pc_id;
      imediato_ex         <= imediato_id;
      dado_fonte1_ex      <= operando1;
      dado_fonte2_ex      <= operando2;
      endereco_fonte1_ex  <= endereco_fonte1;
      endereco_fonte2_ex  <= endereco_fonte2;
      endereco_destino_ex <= endereco_destino;
      controle_ex         <= valido_id ? controle_id : NOP;
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Directed-vector bench for id_ex_register: capture, bypass, load-use, flush, freeze,
// counter saturation (narrow-counter instance) and asynchronous reset.
module tb_id_ex_register;

  logic        clk = 1'b0;
  logic        reset;
  logic        valido_id;
  logic [31:0] pc_id, dado_fonte1, dado_fonte2, imediato_id, wb_dado;
  logic [4:0]  endereco_fonte1, endereco_fonte2, endereco_destino, wb_endereco_destino;
  logic [9:0]  controle_id;
  logic        wb_habilita_escrita, descarta, congela;

  logic        parar_id, valido_ex;
  logic [31:0] pc_ex, imediato_ex, dado_fonte1_ex, dado_fonte2_ex;
  logic [4:0]  endereco_fonte1_ex, endereco_fonte2_ex, endereco_destino_ex;
  logic [9:0]  controle_ex;
  logic [15:0] contador_bolhas;

  logic        s_parar, s_valido;
  logic [31:0] s_pc, s_imm, s_d1, s_d2;
  logic [4:0]  s_a1, s_a2, s_rd;
  logic [9:0]  s_ctl;
  logic [2:0]  s_cont;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_register dut (
    .clk(clk), .reset(reset), .valido_id(valido_id), .pc_id(pc_id),
    .dado_fonte1(dado_fonte1), .dado_fonte2(dado_fonte2),
    .endereco_fonte1(endereco_fonte1), .endereco_fonte2(endereco_fonte2),
    .endereco_destino(endereco_destino), .imediato_id(imediato_id), .controle_id(controle_id),
    .wb_habilita_escrita(wb_habilita_escrita), .wb_endereco_destino(wb_endereco_destino),
    .wb_dado(wb_dado), .descarta(descarta), .congela(congela), .parar_id(parar_id),
    .valido_ex(valido_ex), .pc_ex(pc_ex), .imediato_ex(imediato_ex),
    .dado_fonte1_ex(dado_fonte1_ex), .dado_fonte2_ex(dado_fonte2_ex),
    .endereco_fonte1_ex(endereco_fonte1_ex), .endereco_fonte2_ex(endereco_fonte2_ex),
    .endereco_destino_ex(endereco_destino_ex), .controle_ex(controle_ex),
    .contador_bolhas(contador_bolhas)
  );

  // Narrow counter copy so saturation is reachable in a few cycles.
  id_ex_register #(.LARGURA_CONTADOR(3)) dut_sat (
    .clk(clk), .reset(reset), .valido_id(valido_id), .pc_id(pc_id),
    .dado_fonte1(dado_fonte1), .dado_fonte2(dado_fonte2),
    .endereco_fonte1(endereco_fonte1), .endereco_fonte2(endereco_fonte2),
    .endereco_destino(endereco_destino), .imediato_id(imediato_id), .controle_id(controle_id),
    .wb_habilita_escrita(wb_habilita_escrita), .wb_endereco_destino(wb_endereco_destino),
    .wb_dado(wb_dado), .descarta(descarta), .congela(congela), .parar_id(s_parar),
    .valido_ex(s_valido), .pc_ex(s_pc), .imediato_ex(s_imm),
    .dado_fonte1_ex(s_d1), .dado_fonte2_ex(s_d2),
    .endereco_fonte1_ex(s_a1), .endereco_fonte2_ex(s_a2),
    .endereco_destino_ex(s_rd), .controle_ex(s_ctl), .contador_bolhas(s_cont)
  );

  typedef struct {
    logic [31:0] vid, pc, d1, d2, a1, a2, rd, imm, ctl, wbe, wba, wbd, desc, cong;
    logic [31:0] e_parar, e_vex, e_pc, e_d1, e_d2, e_a1, e_a2, e_rd, e_imm, e_ctl, e_bol;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vid, input logic [31:0] pc, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic [9:0] ctl,
                       input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic desc, input logic cong);
    valido_id = vid; pc_id = pc; dado_fonte1 = d1; dado_fonte2 = d2;
    endereco_fonte1 = a1; endereco_fonte2 = a2; endereco_destino = rd;
    imediato_id = imm; controle_id = ctl; wb_habilita_escrita = wbe;
    wb_endereco_destino = wba; wb_dado = wbd; descarta = desc; congela = cong;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".valido_ex"}, {31'b0, valido_ex}, 32'h0);
    chk({tag, ".pc_ex"}, pc_ex, 32'h0);
    chk({tag, ".d1_ex"}, dado_fonte1_ex, 32'h0);
    chk({tag, ".d2_ex"}, dado_fonte2_ex, 32'h0);
    chk({tag, ".rd_ex"}, {27'b0, endereco_destino_ex}, 32'h0);
    chk({tag, ".ctl_ex"}, {22'b0, controle_ex}, 32'h0);
    chk({tag, ".bolhas"}, {16'b0, contador_bolhas}, 32'h0);
    chk({tag, ".bolhas_sat"}, {29'b0, s_cont}, 32'h0);
  endtask

  initial begin
    //        vid pc      d1          d2          a1 a2 rd imm         ctl    wbe wba wbd         dsc cng | parar vex pc      d1          d2          a1 a2 rd imm         ctl    bol
    vecs[0]  = '{1, 32'h100, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 2, 3, 32'h10, 32'h011, 0, 0, 0, 0, 0,  0, 1, 32'h100, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 2, 3, 32'h10, 32'h011, 0};
    vecs[1]  = '{1, 32'h104, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 2, 4, 32'h4, 32'h001, 1, 1, 32'hDEADBEEF, 0, 0,  0, 1, 32'h104, 32'hDEADBEEF, 32'h5A5A5A5A, 1, 2, 4, 32'h4, 32'h001, 0};
    vecs[2]  = '{1, 32'h108, 32'h0, 32'h12345678, 0, 2, 6, 0, 32'h001, 1, 0, 32'hCAFEBABE, 0, 0,  0, 1, 32'h108, 32'h0, 32'h12345678, 0, 2, 6, 0, 32'h001, 0};
    vecs[3]  = '{1, 32'h10C, 32'h1, 32'h2, 7, 7, 5, 32'h20, 32'h00B, 1, 7, 32'h77777777, 0, 0,  0, 1, 32'h10C, 32'h77777777, 32'h77777777, 7, 7, 5, 32'h20, 32'h00B, 0};
    vecs[4]  = '{1, 32'h110, 32'h11, 32'h22, 6, 5, 8, 0, 32'h001, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[5]  = '{1, 32'h110, 32'h11, 32'h22, 6, 5, 8, 0, 32'h001, 0, 0, 0, 0, 0,  0, 1, 32'h110, 32'h11, 32'h22, 6, 5, 8, 0, 32'h001, 1};
    vecs[6]  = '{0, 32'h114, 32'h3, 32'h4, 8, 9, 10, 0, 32'h3FF, 0, 0, 0, 0, 0,  0, 0, 32'h114, 32'h3, 32'h4, 8, 9, 10, 0, 0, 1};
    vecs[7]  = '{1, 32'h118, 32'hAAAA, 32'hBBBB, 1, 2, 5, 32'h8, 32'h00A, 0, 0, 0, 0, 0,  0, 1, 32'h118, 32'hAAAA, 32'hBBBB, 1, 2, 5, 32'h8, 32'h00A, 1};
    vecs[8]  = '{1, 32'h11C, 32'h1, 32'h2, 0, 5, 3, 0, 32'h001, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{1, 32'h11C, 32'h5, 32'h6, 3, 4, 9, 0, 32'h002, 0, 0, 0, 0, 0,  0, 1, 32'h11C, 32'h5, 32'h6, 3, 4, 9, 0, 32'h002, 1};
    vecs[10] = '{0, 32'h120, 32'h9, 32'h0, 9, 0, 0, 0, 32'h000, 0, 0, 0, 0, 0,  0, 0, 32'h120, 32'h9, 32'h0, 9, 0, 0, 0, 0, 1};
    vecs[11] = '{1, 32'h124, 32'h1, 32'h2, 1, 2, 9, 32'hFFFFFFFC, 32'h002, 0, 0, 0, 0, 0,  0, 1, 32'h124, 32'h1, 32'h2, 1, 2, 9, 32'hFFFFFFFC, 32'h002, 1};
    vecs[12] = '{1, 32'h128, 32'hAB, 32'hCD, 9, 0, 4, 0, 32'h001, 1, 1, 32'hFFFF, 0, 1,  1, 1, 32'h124, 32'h1, 32'h2, 1, 2, 9, 32'hFFFFFFFC, 32'h002, 1};
    vecs[13] = '{1, 32'h200, 32'hAB, 32'hCD, 0, 0, 4, 0, 32'h001, 0, 0, 0, 0, 1,  1, 1, 32'h124, 32'h1, 32'h2, 1, 2, 9, 32'hFFFFFFFC, 32'h002, 1};
    vecs[14] = '{1, 32'h300, 32'h77, 32'h88, 9, 3, 4, 0, 32'h001, 0, 0, 0, 0, 1,  1, 1, 32'h124, 32'h1, 32'h2, 1, 2, 9, 32'hFFFFFFFC, 32'h002, 1};
    vecs[15] = '{1, 32'h300, 32'h33, 32'h0, 9, 0, 2, 0, 32'h001, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
    vecs[16] = '{1, 32'h128, 32'h0, 32'h0, 0, 0, 0, 0, 32'h002, 0, 0, 0, 0, 0,  0, 1, 32'h128, 0, 0, 0, 0, 0, 0, 32'h002, 2};
    vecs[17] = '{1, 32'h12C, 32'h0, 32'h0, 0, 0, 1, 0, 32'h001, 0, 0, 0, 0, 0,  0, 1, 32'h12C, 0, 0, 0, 0, 1, 0, 32'h001, 2};

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #3 reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].vid[0], vecs[i].pc, vecs[i].d1, vecs[i].d2, vecs[i].a1[4:0],
            vecs[i].a2[4:0], vecs[i].rd[4:0], vecs[i].imm, vecs[i].ctl[9:0],
            vecs[i].wbe[0], vecs[i].wba[4:0], vecs[i].wbd, vecs[i].desc[0], vecs[i].cong[0]);
      #3;
      chk($sformatf("v%0d.parar_id", i), {31'b0, parar_id}, vecs[i].e_parar);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.valido_ex", i), {31'b0, valido_ex}, vecs[i].e_vex);
      chk($sformatf("v%0d.pc_ex", i), pc_ex, vecs[i].e_pc);
      chk($sformatf("v%0d.d1_ex", i), dado_fonte1_ex, vecs[i].e_d1);
      chk($sformatf("v%0d.d2_ex", i), dado_fonte2_ex, vecs[i].e_d2);
      chk($sformatf("v%0d.a1_ex", i), {27'b0, endereco_fonte1_ex}, vecs[i].e_a1);
      chk($sformatf("v%0d.a2_ex", i), {27'b0, endereco_fonte2_ex}, vecs[i].e_a2);
      chk($sformatf("v%0d.rd_ex", i), {27'b0, endereco_destino_ex}, vecs[i].e_rd);
      chk($sformatf("v%0d.imm_ex", i), imediato_ex, vecs[i].e_imm);
      chk($sformatf("v%0d.ctl_ex", i), {22'b0, controle_ex}, vecs[i].e_ctl);
      chk($sformatf("v%0d.bolhas", i), {16'b0, contador_bolhas}, vecs[i].e_bol);
    end

    // Alternate load capture and dependent read: one bubble per pair of cycles.
    for (int j = 0; j < 10; j++) begin
      drive(1, 32'h400, 32'h1, 32'h2, 0, 0, 5, 0, 10'h002, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      drive(1, 32'h404, 32'h1, 32'h2, 5, 0, 6, 0, 10'h001, 0, 0, 0, 0, 0);
      #3;
      chk($sformatf("sat%0d.parar_id", j), {31'b0, parar_id}, 32'h1);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.bolhas", j), {16'b0, contador_bolhas}, 32'(3 + j));
      chk($sformatf("sat%0d.bolhas_sat", j), {29'b0, s_cont}, (3 + j > 7) ? 32'd7 : 32'(3 + j));
    end

    drive(1, 32'h500, 32'h55, 32'h66, 1, 2, 7, 32'h9, 10'h002, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_reset.valido_ex", {31'b0, valido_ex}, 32'h1);
    #3 reset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("after_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- Pipeline register between the ID stage (register_file, decoder) and EX.
- Captures the decoded instruction, both register operands, the immediate and the control bundle.
- Applies a write-back bypass for same-cycle WB writes, detects load-use hazards (stalls ID and injects a bubble), and honours flush from EX branch resolution and freeze from MEM.
- Counts injected load-use bubbles for performance monitoring.

Parameters:
LARGURA_DADO, 32, width of register data, immediate and PC
LARGURA_ENDERECO, 5, register address width
LARGURA_CONTROLE, 10, width of the control bundle
LARGURA_CONTADOR, 16, width of the bubble counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; reset=0 clears all state immediately
valido_id  in  1  ID holds a valid instruction
pc_id  in  32  PC of the ID instruction
dado_fonte1  in  32  register_file read port 1
dado_fonte2  in  32  register_file read port 2
endereco_fonte1  in  5  rs1
endereco_fonte2  in  5  rs2
endereco_destino  in  5  rd
imediato_id  in  32  sign-extended immediate
controle_id  in  10  control bundle: [0] habilita_escrita, [1] le_memoria, [2] escreve_memoria, [3] mem_para_reg, [4] alu_src, [5] desvio, [9:6] alu_op
wb_habilita_escrita  in  1  WB stage writes this cycle
wb_endereco_destino  in  5  WB target register
wb_dado  in  32  WB write data
descarta  in  1  flush: branch or jump taken in EX
congela  in  1  hold: MEM stage not accepting
parar_id  out  1  combinational; holds PC and IF/ID
valido_ex  out  1  EX instruction valid
pc_ex, imediato_ex  out  32  registered copies
dado_fonte1_ex, dado_fonte2_ex  out  32  registered operands after bypass
endereco_fonte1_ex, endereco_fonte2_ex, endereco_destino_ex  out  5  registered addresses, used by the EX forwarding unit
controle_ex  out  10  registered control bundle
contador_bolhas  out  16  count of load-use bubbles

Behaviour:
- Reset (reset=0, asynchronous): every registered output is 0, including valido_ex, controle_ex and contador_bolhas. Takes effect without a clock edge. Release is sampled on the next rising edge.
- Hazard:
  - carga_uso = valido_id & valido_ex & controle_ex[1] & (endereco_destino_ex != 0) & (endereco_destino_ex == endereco_fonte1 | endereco_destino_ex == endereco_fonte2).
  - Compares both sources unconditionally. A false positive costs one cycle, which is acceptable.
- parar_id = (carga_uso | congela) & ~descarta. Purely combinational, no registered latency.
- Per-edge action, first match wins:
  1. descarta=1: bubble. valido_ex=0, controle_ex=0; other fields don't-care but driven to 0.
  2. congela=1: all EX registers hold their values.
  3. carga_uso=1: bubble as in 1. contador_bolhas increments.
  4. Otherwise: capture all ID fields. valido_ex=valido_id. controle_ex=controle_id when valido_id=1, else 0.
- Bypass on capture: dado_fonte1_ex = wb_dado if wb_habilita_escrita & wb_endereco_destino == endereco_fonte1 & endereco_fonte1 != 0, else dado_fonte1. Same rule for fonte2. Both may bypass in the same cycle.
- x0: an operand addressed at 0 is always captured as the register_file value (0). Bypass never applies to x0.
- Counter: saturates at all-ones; no wrap-around. It is not incremented on a flush bubble or during congela.
- Latency: one cycle ID to EX. A load-use stall costs exactly one bubble cycle. On the next edge the same ID instruction is captured, provided the load has left EX.
- Simultaneous descarta and congela: descarta wins. The EX instruction is squashed and a bubble is inserted.
- An invalid instruction in ID never triggers carga_uso.

Decomposition:
- Shared package pipeline_pkg:
  - control-bundle field index constants (BIT_HABILITA_ESCRITA … CAMPO_ALU_OP)
  - LARGURA_CONTROLE
  - CONTROLE_NOP = 0
  - alu_op encodings
- One natural sub-module: detector_hazard_carga, combinational, producing carga_uso. It is reused by the future stall controller.
- Bypass muxes and pipeline registers stay in id_ex_register.

Test Plan:
- Reset mid-run: load several instructions, drive reset=0 between edges → all outputs 0 immediately, contador_bolhas=0.
- Normal capture: valido_id=1, rs1=1 data A5A5A5A5, rs2=2 data 5A5A5A5A, rd=3, controle_id=0x011 → next edge EX fields equal inputs, valido_ex=1, parar_id=0.
- WB bypass: wb writes x1=DEADBEEF in the same cycle ID reads x1 as A5A5A5A5 → dado_fonte1_ex=DEADBEEF. Repeat with wb to x0 → captured 0.
- Load-use: EX holds a load (controle_ex[1]=1, rd=5), ID reads rs2=5 → parar_id=1; next edge valido_ex=0, controle_ex=0, contador_bolhas=1. The edge after captures the ID instruction.
- Flush priority: descarta=1 with congela=1 and a pending load-use → bubble inserted, parar_id=0, counter unchanged.
- Freeze: congela=1 for 3 cycles with changing ID inputs → EX outputs constant, parar_id=1 throughout.
